// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//   Receiving end of a VGA timing interface. Samples hsync/vsync on the pixel
//   clock, rebuilds the pixel coordinates of the previous sample, checks each
//   sync edge against the configured mode, and acquires/maintains lock.
//
// Ports:
//   clk_25      in   1  pixel clock, rising edge
//   rst         in   1  asynchronous active-high reset
//   hsync_in    in   1  horizontal sync (active-high, clk_25 domain)
//   vsync_in    in   1  vertical sync (active-high, clk_25 domain)
//   pixel_x     out 10  reconstructed column of the previous sample
//   pixel_y     out 10  reconstructed line of the previous sample
//   active      out  1  locked and inside the visible area
//   locked      out  1  timing lock
//   frame_start out  1  pulse when (0,0) is registered while locked
//   err_pulse   out  1  one pulse per cycle with a timing error
//   err_count   out  8  saturating count of errors seen while locked
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
  parameter int HVID        = 640,
  parameter int HFP         = 16,
  parameter int HS          = 96,
  parameter int HBP         = 48,
  parameter int VVID        = 480,
  parameter int VFP         = 10,
  parameter int VS          = 2,
  parameter int VBP         = 29,
  parameter int LOCK_FRAMES = 2,
  parameter int LOSS_CYCLES = 1600
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  localparam int HC_MAX = HVID + HFP + HS + HBP;
  localparam int VC_MAX = VVID + VFP + VS + VBP;
  localparam int LW     = $clog2(LOSS_CYCLES + 1);

  localparam logic [9:0]    H_LAST      = 10'(HC_MAX - 1);
  localparam logic [9:0]    V_LAST      = 10'(VC_MAX - 1);
  localparam logic [9:0]    HSYNC_BEGIN = 10'(HVID + HFP);
  localparam logic [9:0]    HSYNC_END   = 10'(HVID + HFP + HS);
  localparam logic [9:0]    VSYNC_BEGIN = 10'(VVID + VFP);
  localparam logic [9:0]    HVID_C      = 10'(HVID);
  localparam logic [9:0]    VVID_C      = 10'(VVID);
  localparam logic [LW-1:0] LOSS_LIM    = LW'(LOSS_CYCLES);
  localparam logic [3:0]    GOOD_TARGET = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          hs_prev_q, vs_prev_q;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic [LW-1:0] loss_q, loss_d;
  logic          hs_seen_q, hs_seen_d;
  logic [3:0]    good_q, good_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          active_q, active_d;
  logic          locked_q, locked_d;
  logic          frame_start_q, frame_start_d;
  logic          err_pulse_q, err_pulse_d;

  logic          hs_rise_s, hs_fall_s, vs_rise_s;
  logic [9:0]    h_pred_s, v_pred_s;
  logic          loss_s, err_s;

  // Edge detection, coordinate prediction, loss timer and error detection.
  always_comb begin
    hs_rise_s = hsync_in & ~hs_prev_q;
    hs_fall_s = ~hsync_in & hs_prev_q;
    vs_rise_s = vsync_in & ~vs_prev_q;

    h_pred_s = (h_cnt_q == H_LAST) ? 10'd0 : (h_cnt_q + 10'd1);
    // The line counter only moves when the column wraps to zero.
    if (h_pred_s == 10'd0) begin
      v_pred_s = (v_cnt_q == V_LAST) ? 10'd0 : (v_cnt_q + 10'd1);
    end else begin
      v_pred_s = v_cnt_q;
    end

    // A sync rise re-anchors the counter to where that edge belongs.
    h_cnt_d = hs_rise_s ? HSYNC_BEGIN : h_pred_s;
    v_cnt_d = vs_rise_s ? VSYNC_BEGIN : v_pred_s;

    // Saturating at the limit keeps the loss condition asserted until an
    // hsync edge returns, so re-entering TRACK without hsync fails again.
    if (hs_rise_s) begin
      loss_d = {LW{1'b0}};
    end else if (loss_q == LOSS_LIM) begin
      loss_d = loss_q;
    end else begin
      loss_d = loss_q + LW'(1);
    end
    loss_s = (loss_d == LOSS_LIM);

    if (state_q != ST_SEARCH) begin
      err_s = (hs_rise_s && (h_pred_s != HSYNC_BEGIN)) ||
              (hs_fall_s && (h_pred_s != HSYNC_END)) ||
              (vs_rise_s && ((v_pred_s != VSYNC_BEGIN) || (h_pred_s != 10'd0))) ||
              loss_s;
    end else begin
      err_s = 1'b0;
    end
  end

  // Lock acquisition state machine; an error outranks a same-cycle vs_rise.
  always_comb begin
    state_d   = state_q;
    hs_seen_d = hs_seen_q;
    good_d    = good_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (hs_rise_s) begin
          hs_seen_d = 1'b1;
        end else begin
          hs_seen_d = hs_seen_q;
        end
        if (vs_rise_s && (hs_seen_q || hs_rise_s)) begin
          state_d = ST_TRACK;
          good_d  = 4'd0;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_TRACK: begin
        if (err_s) begin
          good_d = 4'd0;
          if (loss_s) begin
            state_d = ST_SEARCH;
          end else begin
            state_d = ST_TRACK;
          end
        end else if (vs_rise_s) begin
          good_d = good_q + 4'd1;
          if ((good_q + 4'd1) == GOOD_TARGET) begin
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_TRACK;
          end
        end else begin
          state_d = ST_TRACK;
        end
      end
      ST_LOCKED: begin
        if (err_s) begin
          state_d   = ST_SEARCH;
          hs_seen_d = 1'b0;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        hs_seen_d = 1'b0;
        good_d    = 4'd0;
      end
    endcase
  end

  // Output flags are formed from next-state values so they line up with
  // the coordinates registered in the same cycle.
  always_comb begin
    locked_d      = (state_d == ST_LOCKED);
    active_d      = locked_d && (h_cnt_d < HVID_C) && (v_cnt_d < VVID_C);
    frame_start_d = locked_d && (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
    err_pulse_d   = err_s;
  end

  // Sync history, coordinate counters and loss timer.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      loss_q    <= {LW{1'b0}};
    end else begin
      hs_prev_q <= hsync_in;
      vs_prev_q <= vsync_in;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      loss_q    <= loss_d;
    end
  end

  // Lock state, frame qualification counters and registered flags.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      hs_seen_q     <= 1'b0;
      good_q        <= 4'd0;
      err_cnt_q     <= 8'd0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_seen_q     <= hs_seen_d;
      good_q        <= good_d;
      err_cnt_q     <= err_cnt_d;
      active_q      <= active_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign active      = active_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_cnt_q;

endmodule
